// File: rtl/mic_frame_ring.sv
// Multi-channel frame ring: keeps the last 2^DEPTH_LOG2 frames of CH_NUM mic samples in one simple-dual-port RAM.
// Latency: read result 1 cycle after rd_req (2 cycles when MIC_RING_OUT_REG_EN is defined); frame_done/frame_err 1 cycle after the sample.
// Backpressure: none; accepts one sample and one read request per cycle, every cycle.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   in_valid/in_data/in_last - interleaved sample stream, channels 0..CH_NUM-1, in_last on the final channel
//   rd_req/rd_ch/rd_delay    - random read of (channel, frames-ago); delay 0 = newest completed frame
//   rd_valid/rd_data/rd_stale - read result; stale (data forced to 0) when the frame is not yet written
//   fill_level          - completed frames available, saturating at 2^DEPTH_LOG2-1
//   frame_done/frame_err - one-cycle pulses for frame commit / framing error
// Optional: define MIC_RING_OUT_REG_EN to add a RAM output register stage (read latency 2).

module mic_frame_ring #(
    parameter int DATA_W     = 16,
    parameter int CH_LOG2    = 3,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    input  logic                  rd_req,
    input  logic [CH_LOG2-1:0]    rd_ch,
    input  logic [DEPTH_LOG2-1:0] rd_delay,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_stale,
    output logic [DEPTH_LOG2-1:0] fill_level,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int ADDR_W = DEPTH_LOG2 + CH_LOG2;
    localparam int WORDS  = 1 << ADDR_W;
    localparam logic [CH_LOG2-1:0]    CH_LAST  = '1;
    localparam logic [DEPTH_LOG2-1:0] FILL_MAX = '1;

    logic [DATA_W-1:0]     mem [WORDS];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [CH_LOG2-1:0]    ch_cnt;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic is_last_ch;
    logic commit;
    logic err;

    assign is_last_ch = (ch_cnt == CH_LAST);
    assign commit     = in_valid & in_last & is_last_ch;
    // Either an early in_last or a missing in_last on the final channel.
    assign err        = in_valid & (in_last ^ is_last_ch);

    // RAM contents are never cleared; fill_level decides what is readable.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            mem[{wr_ptr, ch_cnt}] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            ch_cnt     <= '0;
            fill_level <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= commit;
            frame_err  <= err;
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
                ch_cnt <= '0;
                // Saturate one below the slot count: one slot is always the frame being filled.
                if (fill_level != FILL_MAX) begin
                    fill_level <= fill_level + 1'b1;
                end
            end else if (err) begin
                // Keep wr_ptr so the broken frame's slot is simply rewritten.
                ch_cnt <= '0;
            end else if (in_valid) begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] rd_slot;
    logic                  stale_now;

    // Uses pre-edge wr_ptr/fill_level, so a commit in the same cycle is invisible to this read.
    assign rd_slot   = wr_ptr - DEPTH_LOG2'(1) - rd_delay;
    assign stale_now = (rd_delay >= fill_level);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_stale;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_stale <= 1'b0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req) begin
                s1_stale <= stale_now;
                s1_data  <= stale_now ? '0 : mem[{rd_slot, rd_ch}];
            end
        end
    end

`ifdef MIC_RING_OUT_REG_EN
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_stale;

    // Output register stage; data/stale only move with a valid so rd_data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_stale <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= s1_data;
                s2_stale <= s1_stale;
            end
        end
    end

    assign rd_valid = s2_valid;
    assign rd_data  = s2_data;
    assign rd_stale = s2_stale;
`else
    assign rd_valid = s1_valid;
    assign rd_data  = s1_data;
    assign rd_stale = s1_stale;
`endif

endmodule

// File: tb/tb_mic_frame_ring.sv
// Directed bench for mic_frame_ring at default parameters (16-bit, 8 channels, 64 slots).
// Latency: follows the build; 2-cycle reads when MIC_RING_OUT_REG_EN is defined.
// Backpressure: not applicable; stimulus is driven on the falling edge, outputs checked on the falling edge.

module tb_mic_frame_ring;

`ifdef MIC_RING_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        rd_req;
    logic [2:0]  rd_ch;
    logic [5:0]  rd_delay;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_stale;
    logic [5:0]  fill_level;
    logic        frame_done;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    always #5 clk = ~clk;

    mic_frame_ring #(.DATA_W(16), .CH_LOG2(3), .DEPTH_LOG2(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .rd_req     (rd_req),
        .rd_ch      (rd_ch),
        .rd_delay   (rd_delay),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_stale   (rd_stale),
        .fill_level (fill_level),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        rd_req   = 1'b0;
        rd_ch    = '0;
        rd_delay = '0;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // One full frame, sample value = frame*16 + ch.
    task automatic write_frame(input int frame);
        for (int ch = 0; ch < 8; ch++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(frame * 16 + ch);
            in_last  = (ch == 7);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] ch, input logic [5:0] dly,
                           input logic [15:0] exp_data, input logic exp_stale);
        @(negedge clk);
        rd_req   = 1'b1;
        rd_ch    = ch;
        rd_delay = dly;
        @(negedge clk);
        rd_req = 1'b0;
        for (int i = 1; i < LAT; i++) begin
            chk({tag, "_early"}, 32'(rd_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, "_vld"},   32'(rd_valid), 32'd1);
        chk({tag, "_dat"},   32'(rd_data),  32'(exp_data));
        chk({tag, "_stale"}, 32'(rd_stale), 32'(exp_stale));
        @(negedge clk);
        chk({tag, "_idle"}, 32'(rd_valid), 32'd0);
        chk({tag, "_hold"}, 32'(rd_data),  32'(exp_data));
    endtask

    logic [15:0] bexp [3];

    initial begin
        do_reset();

        // ---------------- reset state + stale read on empty ring ----------------
        chk("rst_vld",   32'(rd_valid),   32'd0);
        chk("rst_dat",   32'(rd_data),    32'd0);
        chk("rst_fill",  32'(fill_level), 32'd0);
        chk("rst_done",  32'(frame_done), 32'd0);
        chk("rst_err",   32'(frame_err),  32'd0);
        do_read("empty", 3'd0, 6'd0, 16'h0000, 1'b1);

        // ---------------- three frames ----------------
        for (int f = 0; f < 3; f++) write_frame(f);
        @(negedge clk);
        chk("f3_fill", 32'(fill_level), 32'd3);
        chk("f3_done", 32'(done_cnt),   32'd3);
        do_read("f3_d0", 3'd5, 6'd0, 16'h0025, 1'b0);
        do_read("f3_d1", 3'd5, 6'd1, 16'h0015, 1'b0);
        do_read("f3_d2", 3'd5, 6'd2, 16'h0005, 1'b0);
        do_read("f3_d3", 3'd5, 6'd3, 16'h0000, 1'b1);

        // Back-to-back reads, one per cycle.
        bexp[0] = 16'h0021;
        bexp[1] = 16'h0011;
        bexp[2] = 16'h0001;
        for (int j = 0; j < 3 + LAT; j++) begin
            @(negedge clk);
            if (j >= LAT) begin
                chk("b2b_vld", 32'(rd_valid), 32'd1);
                chk("b2b_dat", 32'(rd_data),  32'(bexp[j - LAT]));
            end
            if (j < 3) begin
                rd_req   = 1'b1;
                rd_ch    = 3'd1;
                rd_delay = 6'(j);
            end else begin
                rd_req = 1'b0;
            end
        end

        // ---------------- 70 frames: saturation and wrap ----------------
        do_reset();
        for (int f = 0; f < 70; f++) write_frame(f);
        @(negedge clk);
        chk("sat_fill", 32'(fill_level), 32'd63);
        chk("sat_done", 32'(done_cnt),   32'd70);
        do_read("sat_d62", 3'd0, 6'd62, 16'h0070, 1'b0);
        do_read("sat_d0",  3'd3, 6'd0,  16'h0453, 1'b0);
        do_read("sat_d63", 3'd0, 6'd63, 16'h0000, 1'b1);

        // ---------------- framing errors ----------------
        do_reset();
        write_frame(0);
        write_frame(1);
        // Early in_last on channel 4.
        for (int ch = 0; ch < 5; ch++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(16'h00E0 + ch);
            in_last  = (ch == 4);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("err1_pulse", 32'(frame_err),  32'd1);
        chk("err1_done",  32'(frame_done), 32'd0);
        @(negedge clk);
        chk("err1_fill",  32'(fill_level), 32'd2);
        write_frame(32);
        @(negedge clk);
        chk("err1_fill2", 32'(fill_level), 32'd3);
        do_read("err1_d0", 3'd4, 6'd0, 16'h0204, 1'b0);
        do_read("err1_d1", 3'd4, 6'd1, 16'h0014, 1'b0);
        // Missing in_last on channel 7.
        for (int ch = 0; ch < 8; ch++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(16'h00F0 + ch);
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("err2_pulse", 32'(frame_err), 32'd1);
        @(negedge clk);
        chk("err2_fill",  32'(fill_level), 32'd3);
        chk("err2_cnt",   32'(err_cnt),    32'd2);
        write_frame(48);
        do_read("err2_d0", 3'd7, 6'd0, 16'h0307, 1'b0);
        do_read("err2_d1", 3'd7, 6'd1, 16'h0207, 1'b0);

        // ---------------- commit and read in the same cycle ----------------
        do_reset();
        for (int f = 0; f < 9; f++) write_frame(f);
        for (int ch = 0; ch < 7; ch++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(9 * 16 + ch);
            in_last  = 1'b0;
        end
        @(negedge clk);
        in_data  = 16'h0097;
        in_last  = 1'b1;
        rd_req   = 1'b1;
        rd_ch    = 3'd2;
        rd_delay = 6'd0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rd_req   = 1'b0;
        chk("same_done", 32'(frame_done), 32'd1);
        if (LAT > 1) begin
            chk("same_early", 32'(rd_valid), 32'd0);
            @(negedge clk);
        end
        chk("same_vld",   32'(rd_valid), 32'd1);
        chk("same_dat",   32'(rd_data),  32'h0082);
        chk("same_stale", 32'(rd_stale), 32'd0);
        chk("same_fill",  32'(fill_level), 32'd10);
        do_read("after_same", 3'd2, 6'd0, 16'h0092, 1'b0);

        // ---------------- reset while a read is in flight ----------------
        @(negedge clk);
        rd_req   = 1'b1;
        rd_ch    = 3'd1;
        rd_delay = 6'd0;
        if (LAT > 1) begin
            @(negedge clk);
            rd_req = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        reset  = 1'b0;
        chk("rstrd_vld0", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("rstrd_vld1", 32'(rd_valid),   32'd0);
        chk("rstrd_dat",  32'(rd_data),    32'd0);
        chk("rstrd_fill", 32'(fill_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
